// File: rtl/chan_mux_pkg.sv
// Shared definitions for the channel multiplexer: select-mode encodings,
// output register state and the index-width helper.
package chan_mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mux_state_t;

    // Index width for n channels, never less than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr+1 and
// wraps modulo CHANNELS, so the last winner has the lowest priority.
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SELW     = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    output logic                grant_valid,
    output logic [SELW-1:0]     grant_idx
);

    localparam int PADW = 1 << SELW;

    logic [PADW-1:0]     req_pad;
    logic [SELW-1:0]     cand_idx [CHANNELS];
    logic [CHANNELS-1:0] cand_req;

    // Padding keeps indices >= CHANNELS permanently unrequested.
    assign req_pad = PADW'(req);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_cand
        logic [SELW:0] sum;
        assign sum          = {1'b0, ptr} + (SELW+1)'(gi + 1);
        assign cand_idx[gi] = (sum >= (SELW+1)'(CHANNELS))
                            ? SELW'(sum - (SELW+1)'(CHANNELS))
                            : sum[SELW-1:0];
        assign cand_req[gi] = req_pad[cand_idx[gi]];
    end

    // Walk from the lowest priority up so the nearest candidate wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/chan_mux_reg.sv
// N:1 channel multiplexer with one registered output stage and valid/ready
// handshakes; channel choice is either explicit (sel) or round-robin.
module chan_mux_reg
    import chan_mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SELW     = clog2_min1(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int PADW = 1 << SELW;

    mux_state_t       state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [SELW-1:0]  chan_reg, chan_next;
    logic [SELW-1:0]  rr_ptr_reg, rr_ptr_next;

    logic [WIDTH-1:0] chan_data [CHANNELS];
    logic [PADW-1:0]  valid_pad;
    logic             load;
    logic             sel_in_range;
    logic             sel_grant;
    logic             rr_grant_valid;
    logic [SELW-1:0]  rr_grant_idx;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic             take;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    assign valid_pad = PADW'(in_valid);
    assign out_valid = (state_reg == ST_FULL);
    assign out_data  = data_reg;
    assign out_chan  = chan_reg;

    // The register can accept whenever it is empty or being drained this edge.
    assign load = ~out_valid | out_ready;

    assign sel_in_range = ({1'b0, sel} < (SELW+1)'(CHANNELS));
    assign sel_grant    = sel_in_range & valid_pad[sel];

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr_reg),
        .grant_valid (rr_grant_valid),
        .grant_idx   (rr_grant_idx)
    );

    assign grant_valid = (mode == MODE_RR) ? rr_grant_valid : sel_grant;
    assign grant_idx   = (mode == MODE_RR) ? rr_grant_idx   : sel;
    assign take        = ~reset & load & grant_valid;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
        assign in_ready[gi] = take & (grant_idx == SELW'(gi));
    end

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        chan_next   = chan_reg;
        rr_ptr_next = rr_ptr_reg;
        if (take) begin
            state_next = ST_FULL;
            data_next  = chan_data[grant_idx];
            chan_next  = grant_idx;
            if (mode == MODE_RR) begin
                rr_ptr_next = grant_idx;
            end
        end else if (out_valid && out_ready) begin
            state_next = ST_EMPTY;
        end
    end

    // rr_ptr resets to the last channel so channel 0 is searched first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_EMPTY;
            data_reg   <= '0;
            chan_reg   <= '0;
            rr_ptr_reg <= SELW'(CHANNELS - 1);
        end else begin
            state_reg  <= state_next;
            data_reg   <= data_next;
            chan_reg   <= chan_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule
